// File: rtl/instr_mem_loader_pkg.sv
// Shared types and constants for the instruction-memory serial loader.
package instr_mem_loader_pkg;

    localparam int DEPTH_DEFAULT  = 59;
    localparam int BYTES_PER_WORD = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        CSUM = 2'd2,
        FIN  = 2'd3
    } state_e;

endpackage

// File: rtl/instr_mem_loader_word_packer.sv
// Packs a byte stream MSB-first into 32-bit words; word_valid fires combinationally
// on the strobe carrying the last byte of a word.
module instr_word_packer
    import instr_mem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  byte_in,
    output logic        word_valid,
    output logic [31:0] word
);

    localparam int CW = $clog2(BYTES_PER_WORD);
    localparam int SW = 8 * (BYTES_PER_WORD - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [SW-1:0] shift_q, shift_d;

    always_comb begin
        cnt_d   = cnt_q;
        shift_d = shift_q;
        if (clear) begin
            cnt_d   = '0;
            shift_d = '0;
        end else if (byte_valid) begin
            cnt_d   = cnt_q + CW'(1);
            shift_d = {shift_q[SW-9:0], byte_in};
        end
    end

    assign word_valid = byte_valid && !clear && (cnt_q == CW'(BYTES_PER_WORD - 1));
    assign word       = {shift_q, byte_in};

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q   <= '0;
            shift_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
        end
    end

endmodule

// File: rtl/instr_mem_loader.sv
// Serial loader: packs a byte stream into words, writes them from address 0,
// verifies a trailing checksum and holds the CPU in reset while loading.
module instr_mem_loader
    import instr_mem_loader_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT,
    parameter int AW    = 6
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [AW:0]   word_count,
    input  logic          in_valid,
    input  logic [7:0]    in_data,
    output logic          in_ready,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [31:0]   wr_data,
    output logic          cpu_hold,
    output logic          busy,
    output logic          done,
    output logic          error
);

    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

    state_e        state_q, state_d;
    logic [AW:0]   count_q, count_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [7:0]    sum_q, sum_d;
    logic          error_q, error_d;
    logic          in_ready_q, in_ready_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          cpu_hold_q, cpu_hold_d;
    logic          wr_en_q, wr_en_d;
    logic [AW-1:0] wr_addr_q, wr_addr_d;
    logic [31:0]   wr_data_q, wr_data_d;

    logic          accept, count_ok, last_word, pk_clear, pk_strobe;
    logic          word_valid;
    logic [31:0]   word;

    assign accept    = in_valid && in_ready_q;
    assign count_ok  = (word_count != '0) && (word_count <= DEPTH_W);
    assign last_word = ({1'b0, idx_q} == (count_q - (AW+1)'(1)));
    assign pk_strobe = accept && (state_q == RECV);

    instr_word_packer u_packer (
        .clk        (clk),
        .reset      (reset),
        .clear      (pk_clear),
        .byte_valid (pk_strobe),
        .byte_in    (in_data),
        .word_valid (word_valid),
        .word       (word)
    );

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        idx_d     = idx_q;
        sum_d     = sum_q;
        error_d   = error_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        pk_clear  = 1'b0;
        case (state_q)
            IDLE: if (start) begin
                if (count_ok) begin
                    state_d  = RECV;
                    count_d  = word_count;
                    idx_d    = '0;
                    sum_d    = '0;
                    error_d  = 1'b0;
                    pk_clear = 1'b1;
                end else begin
                    state_d = FIN;
                    error_d = 1'b1;
                end
            end
            RECV: if (accept) begin
                sum_d = sum_q + in_data;
                if (word_valid) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = idx_q;
                    wr_data_d = word;
                    idx_d     = idx_q + AW'(1);
                    if (last_word) state_d = CSUM;
                end
            end
            CSUM: if (accept) begin
                error_d = error_q | (in_data != sum_q);
                state_d = FIN;
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase

        in_ready_d = (state_d == RECV) || (state_d == CSUM);
        busy_d     = (state_d != IDLE);
        done_d     = (state_d == FIN);
        // A rejected start reaches FIN straight from IDLE with hold low; keep it low there.
        cpu_hold_d = (state_d == RECV) || (state_d == CSUM) || ((state_d == FIN) && cpu_hold_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            count_q    <= '0;
            idx_q      <= '0;
            sum_q      <= '0;
            error_q    <= 1'b0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            cpu_hold_q <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            idx_q      <= idx_d;
            sum_q      <= sum_d;
            error_q    <= error_d;
            in_ready_q <= in_ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            cpu_hold_q <= cpu_hold_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
        end
    end

    assign in_ready = in_ready_q;
    assign wr_en    = wr_en_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;
    assign cpu_hold = cpu_hold_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign error    = error_q;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Self-checking bench for instr_mem_loader: table vectors, random loads and
// hand-written reset / restart sequences against a word-list reference model.
module tb_instr_mem_loader;

    localparam int DEPTH = 59;
    localparam int AW    = 6;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [AW:0]   word_count = '0;
    logic          in_valid = 1'b0;
    logic [7:0]    in_data = '0;
    logic          in_ready, wr_en, cpu_hold, busy, done, error;
    logic [AW-1:0] wr_addr;
    logic [31:0]   wr_data;

    instr_mem_loader #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .word_count (word_count),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .cpu_hold   (cpu_hold),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic [AW-1:0] wa_q[$];
    logic [31:0]   wd_q[$];

    always @(negedge clk) begin
        if (wr_en) begin
            wa_q.push_back(wr_addr);
            wd_q.push_back(wr_data);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int gap_of(input int mode);
        if (mode == 1) return 1;
        if (mode == 2) return int'($urandom_range(1, 3));
        return 0;
    endfunction

    // Called at a negedge; returns at the negedge after the byte is accepted.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int t;
        for (int g = 0; g < gap; g++) begin
            in_valid = 1'b0;
            in_data  = 8'($urandom);
            @(negedge clk);
        end
        in_valid = 1'b1;
        in_data  = b;
        t = 0;
        while (!in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            checks++;
            failures++;
            $display("FAIL send_timeout: in_ready stayed %0b required 1", in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = 8'($urandom);
    endtask

    // csum_mode: -1 correct checksum, -2 corrupted checksum, otherwise literal byte.
    task automatic run_load(input string tag, input int wc, input logic [7:0] bytes[$],
                            input int csum_mode, input int gapmode, input int restart_at,
                            input logic exp_err, input int exp_writes);
        logic [7:0]  sum;
        logic [7:0]  csum;
        logic [31:0] exp_word;
        bit          bad_cnt;
        int          nw;
        sum = 8'h00;
        foreach (bytes[i]) sum = sum + bytes[i];
        if (csum_mode == -1)      csum = sum;
        else if (csum_mode == -2) csum = sum + 8'h01;
        else                      csum = 8'(csum_mode);
        bad_cnt = (wc < 1) || (wc > DEPTH);
        wa_q.delete();
        wd_q.delete();

        start = 1'b1;
        word_count = (AW+1)'(wc);
        @(negedge clk);
        start = 1'b0;
        if (bad_cnt) begin
            chk({tag, " bad_done"}, 32'(done), 32'd1);
            chk({tag, " bad_error"}, 32'(error), 32'd1);
            chk({tag, " bad_hold"}, 32'(cpu_hold), 32'd0);
            chk({tag, " bad_ready"}, 32'(in_ready), 32'd0);
            @(negedge clk);
            chk({tag, " bad_done_drop"}, 32'(done), 32'd0);
            chk({tag, " bad_hold2"}, 32'(cpu_hold), 32'd0);
            chk({tag, " bad_error_sticky"}, 32'(error), 32'd1);
        end else begin
            chk({tag, " first_ready"}, 32'(in_ready), 32'd1);
            chk({tag, " hold_rise"}, 32'(cpu_hold), 32'd1);
            chk({tag, " busy"}, 32'(busy), 32'd1);
            chk({tag, " error_clr"}, 32'(error), 32'd0);
            foreach (bytes[i]) begin
                if (i == restart_at) begin
                    start = 1'b1;
                    word_count = (AW+1)'(1);
                end
                send_byte(bytes[i], gap_of(gapmode));
                start = 1'b0;
            end
            send_byte(csum, gap_of(gapmode));
            chk({tag, " done"}, 32'(done), 32'd1);
            chk({tag, " error"}, 32'(error), 32'(exp_err));
            chk({tag, " hold_at_done"}, 32'(cpu_hold), 32'd1);
            chk({tag, " writes_by_done"}, 32'(wa_q.size()), 32'(exp_writes));
            @(negedge clk);
            chk({tag, " done_drop"}, 32'(done), 32'd0);
            chk({tag, " hold_fall"}, 32'(cpu_hold), 32'd0);
            chk({tag, " busy_fall"}, 32'(busy), 32'd0);
            repeat (3) @(negedge clk);
            chk({tag, " error_sticky"}, 32'(error), 32'(exp_err));
        end
        chk({tag, " write_count"}, 32'(wa_q.size()), 32'(exp_writes));
        nw = bad_cnt ? 0 : wc;
        for (int w = 0; w < nw && w < wa_q.size(); w++) begin
            exp_word = {bytes[4*w], bytes[4*w+1], bytes[4*w+2], bytes[4*w+3]};
            chk($sformatf("%s addr%0d", tag, w), 32'(wa_q[w]), 32'(w));
            chk($sformatf("%s data%0d", tag, w), wd_q[w], exp_word);
        end
    endtask

    function automatic void rand_bytes(input int wc, output logic [7:0] q[$]);
        q.delete();
        for (int i = 0; i < 4 * wc; i++) q.push_back(8'($urandom));
    endfunction

    typedef struct {
        int   wc;
        int   gapmode;
        bit   csum_bad;
        logic exp_err;
        int   exp_writes;
    } vec_t;

    vec_t tbl[6];

    initial begin
        logic [7:0] q[$];
        logic [7:0] fixed_q[$];
        int wc;
        bit bad;

        tbl[0] = '{0,   0, 1'b0, 1'b1, 0};
        tbl[1] = '{60,  0, 1'b0, 1'b1, 0};
        tbl[2] = '{127, 0, 1'b0, 1'b1, 0};
        tbl[3] = '{1,   0, 1'b0, 1'b0, 1};
        tbl[4] = '{3,   2, 1'b1, 1'b1, 3};
        tbl[5] = '{5,   1, 1'b0, 1'b0, 5};

        repeat (3) @(negedge clk);
        chk("rst in_ready", 32'(in_ready), 32'd0);
        chk("rst wr_en", 32'(wr_en), 32'd0);
        chk("rst wr_addr", 32'(wr_addr), 32'd0);
        chk("rst wr_data", wr_data, 32'd0);
        chk("rst cpu_hold", 32'(cpu_hold), 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst done", 32'(done), 32'd0);
        chk("rst error", 32'(error), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Reference stream from the test plan.
        fixed_q = '{8'h02, 8'h32, 8'h80, 8'h20, 8'h02, 8'h74, 8'hA8, 8'h05};
        run_load("plan_good", 2, fixed_q, 8'hF7, 0, -1, 1'b0, 2);
        if (wd_q.size() >= 2) begin
            chk("plan word0", wd_q[0], 32'h02328020);
            chk("plan word1", wd_q[1], 32'h0274A805);
        end
        run_load("plan_bad", 2, fixed_q, 8'h00, 0, -1, 1'b1, 2);
        run_load("bad_zero", 0, fixed_q, -1, 0, -1, 1'b1, 0);
        run_load("bad_60", 60, fixed_q, -1, 0, -1, 1'b1, 0);
        run_load("gap_alt", 2, fixed_q, -1, 1, -1, 1'b0, 2);
        run_load("gap_rand", 2, fixed_q, -1, 2, -1, 1'b0, 2);

        for (int v = 0; v < 6; v++) begin
            rand_bytes(tbl[v].wc > DEPTH ? 0 : tbl[v].wc, q);
            run_load($sformatf("tbl%0d", v), tbl[v].wc, q, tbl[v].csum_bad ? -2 : -1,
                     tbl[v].gapmode, -1, tbl[v].exp_err, tbl[v].exp_writes);
        end

        for (int r = 0; r < 4; r++) begin
            wc  = int'($urandom_range(1, 8));
            bad = 1'($urandom_range(0, 1));
            rand_bytes(wc, q);
            run_load($sformatf("rnd%0d", r), wc, q, bad ? -2 : -1,
                     int'($urandom_range(0, 2)), -1, bad, wc);
        end

        // Reset after 6 of 8 bytes: partial word dropped, then a clean load from addr 0.
        wa_q.delete();
        wd_q.delete();
        start = 1'b1;
        word_count = (AW+1)'(2);
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 6; i++) send_byte(fixed_q[i], 0);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst in_ready", 32'(in_ready), 32'd0);
        chk("mid_rst wr_en", 32'(wr_en), 32'd0);
        chk("mid_rst wr_addr", 32'(wr_addr), 32'd0);
        chk("mid_rst wr_data", wr_data, 32'd0);
        chk("mid_rst cpu_hold", 32'(cpu_hold), 32'd0);
        chk("mid_rst busy", 32'(busy), 32'd0);
        chk("mid_rst done", 32'(done), 32'd0);
        chk("mid_rst error", 32'(error), 32'd0);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        chk("mid_rst writes", 32'(wa_q.size()), 32'd1);
        chk("mid_rst no_done", 32'(done), 32'd0);
        run_load("post_rst", 2, fixed_q, -1, 0, -1, 1'b0, 2);

        // Full-depth load with a repeated start pulse in the middle.
        rand_bytes(DEPTH, q);
        run_load("full", DEPTH, q, -1, 0, 100, 1'b0, DEPTH);
        if (wa_q.size() == DEPTH) chk("full last_addr", 32'(wa_q[DEPTH-1]), 32'd58);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/instr_mem_loader.md
# instr_mem_loader

Serial programming front-end for the instruction memory. Accepts a byte stream over a valid/ready handshake, packs bytes MSB-first into 32-bit instruction words, and writes them to consecutive word addresses from 0 through the instruction memory's write port. A trailing checksum byte is verified. While a load is in progress, the CPU is held in reset so fetch never sees a partially written program.

## Interface
Parameters:
- DEPTH, 59, number of instruction words in the memory; valid addresses are 0..DEPTH-1
- AW, 6, word-address width; must satisfy 2^AW >= DEPTH

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- start  in  1  single-cycle pulse that begins a load; ignored while busy
- word_count  in  AW+1  number of words to load; sampled on the accepted start
- in_valid  in  1  in_data holds a byte
- in_data  in  8  stream byte
- in_ready  out  1  loader will accept a byte this cycle
- wr_en  out  1  write strobe to the instruction memory
- wr_addr  out  AW  word address of the write
- wr_data  out  32  instruction word to write
- cpu_hold  out  1  keeps the CPU and PC in reset while high
- busy  out  1  a load is in progress
- done  out  1  single-cycle pulse marking the end of a load
- error  out  1  sticky; valid while done is high and held until the next accepted start

## Operation
- States:
  - IDLE
  - RECV: collect data bytes
  - CSUM: await the checksum byte
  - FIN: one cycle; done=1
- IDLE with start=1:
  - word_count in 1..DEPTH: latch the count, clear the byte counter, word index, running sum and error, then go to RECV.
  - word_count of 0 or greater than DEPTH: go to FIN with error=1. No writes occur, and cpu_hold stays 0.
- A byte is accepted when in_valid and in_ready are both high. in_ready=1 only in RECV and CSUM.
- Byte packing order: the first byte of each word goes to bits [31:24], the fourth to bits [7:0].
- Running sum: 8-bit sum of every accepted data byte, modulo 256.
- When the 4th byte of a word is accepted, a write is issued and the word index increments.
- When the 4th byte of the final word is accepted, go to CSUM.
- In CSUM, the accepted byte is compared with the running sum, then go to FIN. error=1 on mismatch.
- Words already written are not rolled back on error.
- FIN goes to IDLE unconditionally.
- start arriving in RECV, CSUM or FIN is ignored and has no side effects.
- busy=1 in RECV, CSUM and FIN.
- cpu_hold=1 from the cycle after a valid start up to and including the FIN cycle.

## Timing
- Reset values: in_ready=0, wr_en=0, wr_addr=0, wr_data=0, cpu_hold=0, busy=0, done=0, error=0; state=IDLE.
- start to first in_ready: 1 cycle.
- 4th byte accepted in cycle N: wr_en=1 in cycle N+1 for exactly one cycle, with wr_addr and wr_data registered. A new byte may be accepted in cycle N+1; there are no throughput bubbles.
- Checksum byte accepted in cycle M: done=1 in cycle M+1. The final word's write also lands in cycle M+1 or earlier, never after done.
- in_valid gaps stall the loader indefinitely with no timeout. in_data is ignored when in_valid=0.
- Reset asserted mid-load: the next cycle shows all reset values. A partial word is discarded, no write is issued, and no done pulse occurs.
- Bad word_count: done=1 in the cycle after start, with error=1.

## Structure
- Shared package: state enum {IDLE, RECV, CSUM, FIN}, DEPTH default, and a BYTES_PER_WORD=4 constant.
- One sub-module, instr_word_packer: shift register plus 2-bit byte counter. It takes a byte and a byte strobe, and emits word_valid with a 32-bit word. The top level holds the FSM, word index, running sum and checksum compare.

## Test plan
- Two-word load: bytes 02 32 80 20 02 74 A8 05, checksum F7. Expect two writes, addr0=0x02328020 then addr1=0x0274A805, followed by done=1, error=0, and cpu_hold falling after done.
- Same stream with checksum 00: both writes still occur, and done=1 with error=1. error stays 1 until the next start.
- start with word_count=0, then with 60: done=1 the next cycle with error=1 each time, no wr_en, and cpu_hold never rises.
- Two-word load with in_valid asserted every other cycle and random 1–3 cycle gaps: identical writes and result. Bytes presented with in_valid=0 are ignored.
- reset after 6 of 8 bytes: all outputs return to reset values with no third write. A following clean load writes from addr 0.
- Full DEPTH=59 load, with start re-pulsed mid-load: the repeat start is ignored. The last write is to addr 58, followed by done with the correct checksum.
